demux_1_2_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer; routes one input beat stream to one of two output streams. Performs the reverse operation of the team's 2:1 mux.
- Output selection is made once per packet, at the first beat, and held until the last beat of that packet.
- Placed after a producer that shares one channel between two consumers.

---
 rtl/demux_1_2_stream_pkg.sv | 19 +
 rtl/demux_out_reg.sv | 34 +++
 rtl/demux_1_2_stream.sv | 113 +++++++++++
 tb/tb_demux_1_2_stream.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1_2_stream_pkg.sv
// Shared definitions for the 1:2 stream demultiplexer: FSM encodings and output selects.
// Optional per-output beat counters are enabled with DEMUX_CNT_EN.
package demux_1_2_stream_pkg;

   typedef enum logic [1:0] {
      DEMUX_IDLE = 2'd0,
      DEMUX_PKT0 = 2'd1,
      DEMUX_PKT1 = 2'd2
   } demux_state_e;

   localparam logic DEMUX_OUT0 = 1'b0;
   localparam logic DEMUX_OUT1 = 1'b1;

   // Packet-in-progress state that locks the given destination.
   function automatic demux_state_e pkt_state(input logic dest);
      return (dest == DEMUX_OUT1) ? DEMUX_PKT1 : DEMUX_PKT0;
   endfunction

endpackage

// File: rtl/demux_out_reg.sv
// One-entry valid/ready holding register for a single demultiplexer output channel.
module demux_out_reg #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              ready,
   output logic              can_load,
   output logic [DATA_W-1:0] data,
   output logic              last,
   output logic              valid
);

   // Loading is allowed when empty or when the held beat leaves this cycle.
   assign can_load = !valid || ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= in_data;
         last  <= in_last;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_1_2_stream.sv
// Registered 1:2 stream demultiplexer; destination is locked per packet at its first beat.
// Define DEMUX_CNT_EN to add per-output transferred-beat counters cnt0/cnt1.
module demux_1_2_stream
   import demux_1_2_stream_pkg::*;
#(
   parameter int unsigned DATA_W = 8
`ifdef DEMUX_CNT_EN
   ,
   parameter int unsigned CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] m0_data,
   output logic              m0_last,
   output logic              m0_valid,
   input  logic              m0_ready,
   output logic [DATA_W-1:0] m1_data,
   output logic              m1_last,
   output logic              m1_valid,
   input  logic              m1_ready
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
`endif
);

   demux_state_e state_q;
   logic         dest;
   logic         can_load0;
   logic         can_load1;
   logic         accept;
   logic         load0;
   logic         load1;

   always_comb begin
      dest = sel;
      unique case (state_q)
         DEMUX_PKT0: dest = DEMUX_OUT0;
         DEMUX_PKT1: dest = DEMUX_OUT1;
         default:    dest = sel;
      endcase
   end

   // s_ready depends only on the selected channel, never on s_valid.
   assign s_ready = (dest == DEMUX_OUT1) ? can_load1 : can_load0;
   assign accept  = s_valid && s_ready;
   assign load0   = accept && (dest == DEMUX_OUT0);
   assign load1   = accept && (dest == DEMUX_OUT1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DEMUX_IDLE;
      end else if (accept) begin
         unique case (state_q)
            DEMUX_IDLE: state_q <= s_last ? DEMUX_IDLE : pkt_state(sel);
            DEMUX_PKT0: state_q <= s_last ? DEMUX_IDLE : DEMUX_PKT0;
            DEMUX_PKT1: state_q <= s_last ? DEMUX_IDLE : DEMUX_PKT1;
            default:    state_q <= DEMUX_IDLE;
         endcase
      end
   end

   demux_out_reg #(
      .DATA_W (DATA_W)
   ) u_out0 (
      .clk      (clk),
      .rst      (rst),
      .load     (load0),
      .in_data  (s_data),
      .in_last  (s_last),
      .ready    (m0_ready),
      .can_load (can_load0),
      .data     (m0_data),
      .last     (m0_last),
      .valid    (m0_valid)
   );

   demux_out_reg #(
      .DATA_W (DATA_W)
   ) u_out1 (
      .clk      (clk),
      .rst      (rst),
      .load     (load1),
      .in_data  (s_data),
      .in_last  (s_last),
      .ready    (m1_ready),
      .can_load (can_load1),
      .data     (m1_data),
      .last     (m1_last),
      .valid    (m1_valid)
   );

`ifdef DEMUX_CNT_EN
   // Counters wrap naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (m0_valid && m0_ready) cnt0 <= cnt0 + 1'b1;
         if (m1_valid && m1_ready) cnt1 <= cnt1 + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_demux_1_2_stream.sv
// Self-checking bench for demux_1_2_stream: per-output scoreboards fed on accept.
// Counter checks are compiled in when DEMUX_CNT_EN is defined.
module tb_demux_1_2_stream;

   localparam int unsigned DATA_W = 8;
`ifdef DEMUX_CNT_EN
   localparam int unsigned CNT_W  = 4;
`endif

   logic              clk;
   logic              rst;
   logic              sel;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] m0_data;
   logic              m0_last;
   logic              m0_valid;
   logic              m0_ready;
   logic [DATA_W-1:0] m1_data;
   logic              m1_last;
   logic              m1_valid;
   logic              m1_ready;
`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0]  cnt0;
   logic [CNT_W-1:0]  cnt1;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int model_state = 0;  // 0 idle, 1 pkt0, 2 pkt1

   logic [DATA_W:0] q0[$];
   logic [DATA_W:0] q1[$];

   demux_1_2_stream #(
      .DATA_W (DATA_W)
`ifdef DEMUX_CNT_EN
      ,
      .CNT_W  (CNT_W)
`endif
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sel      (sel),
      .s_data   (s_data),
      .s_last   (s_last),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .m0_data  (m0_data),
      .m0_last  (m0_last),
      .m0_valid (m0_valid),
      .m0_ready (m0_ready),
      .m1_data  (m1_data),
      .m1_last  (m1_last),
      .m1_valid (m1_valid),
      .m1_ready (m1_ready)
`ifdef DEMUX_CNT_EN
      ,
      .cnt0     (cnt0),
      .cnt1     (cnt1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: a handshake seen at the falling edge completes on the next rising edge.
   always @(negedge clk) begin
      logic [DATA_W:0] exp_item;
      if (!rst && m0_valid && m0_ready) begin
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL out0_unexpected got data=%h last=%b required none", m0_data, m0_last);
         end else begin
            exp_item = q0.pop_front();
            if ({m0_last, m0_data} !== exp_item) begin
               errors++;
               $display("FAIL out0_beat got last=%b data=%h required last=%b data=%h",
                        m0_last, m0_data, exp_item[DATA_W], exp_item[DATA_W-1:0]);
            end
         end
      end
      if (!rst && m1_valid && m1_ready) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL out1_unexpected got data=%h last=%b required none", m1_data, m1_last);
         end else begin
            exp_item = q1.pop_front();
            if ({m1_last, m1_data} !== exp_item) begin
               errors++;
               $display("FAIL out1_beat got last=%b data=%h required last=%b data=%h",
                        m1_last, m1_data, exp_item[DATA_W], exp_item[DATA_W-1:0]);
            end
         end
      end
   end

   // Drives one beat and waits for its accept; returns #1 after the accepting edge with
   // s_valid still high so consecutive calls stream back-to-back.
   task automatic send_beat(input logic bsel, input logic [DATA_W-1:0] bdata, input logic blast);
      int  wait_cyc = 0;
      int  mdest;
      bit  ok = 0;
      sel     = bsel;
      s_data  = bdata;
      s_last  = blast;
      s_valid = 1'b1;
      while (wait_cyc < 100) begin
         @(negedge clk);
         if (s_ready === 1'b1) begin
            ok = 1;
            break;
         end
         wait_cyc++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout data=%h got s_ready=0 for 100 cycles required 1", bdata);
         s_valid = 1'b0;
         return;
      end
      mdest = (model_state == 0) ? int'(bsel) : model_state - 1;
      if (mdest == 0) q0.push_back({blast, bdata});
      else            q1.push_back({blast, bdata});
      if (blast) model_state = 0;
      else       model_state = mdest + 1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      q0.delete();
      q1.delete();
      model_state = 0;
      checks++;
      if (m0_valid !== 1'b0 || m1_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got m0=%b m1=%b required 0 0", m0_valid, m1_valid);
      end
      checks++;
      if (m0_data !== '0 || m1_data !== '0 || m0_last !== 1'b0 || m1_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_data got %h/%b %h/%b required 00/0 00/0",
                  m0_data, m0_last, m1_data, m1_last);
      end
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_s_ready got %b required 1", s_ready);
      end
      checks++;
      if (dut.state_q !== 2'd0) begin
         errors++;
         $display("FAIL reset_state got %0d required 0", dut.state_q);
      end
`ifdef DEMUX_CNT_EN
      checks++;
      if (cnt0 !== '0 || cnt1 !== '0) begin
         errors++;
         $display("FAIL reset_cnt got %0d %0d required 0 0", cnt0, cnt1);
      end
`endif
   endtask

   task automatic test_single_beat;
      m0_ready = 1'b1;
      m1_ready = 1'b1;
      send_beat(1'b0, 8'hA5, 1'b1);
      checks++;
      if (m0_valid !== 1'b1 || m0_data !== 8'hA5 || m1_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_out0 got m0v=%b m0d=%h m1v=%b required 1 a5 0",
                  m0_valid, m0_data, m1_valid);
      end
      send_beat(1'b1, 8'h3C, 1'b1);
      checks++;
      if (m1_valid !== 1'b1 || m1_data !== 8'h3C || m0_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_out1 got m1v=%b m1d=%h m0v=%b required 1 3c 0",
                  m1_valid, m1_data, m0_valid);
      end
      idle(2);
   endtask

   task automatic test_packet_lock;
      for (int i = 0; i < 4; i++) begin
         send_beat(i[0], 8'h10 + 8'(i), (i == 3));
      end
      checks++;
      if (m0_valid !== 1'b1 || m0_last !== 1'b1 || m0_data !== 8'h13 || m1_valid !== 1'b0) begin
         errors++;
         $display("FAIL lock_tail got m0v=%b m0l=%b m0d=%h m1v=%b required 1 1 13 0",
                  m0_valid, m0_last, m0_data, m1_valid);
      end
      send_beat(1'b1, 8'h20, 1'b1);
      checks++;
      if (m1_valid !== 1'b1 || m1_data !== 8'h20) begin
         errors++;
         $display("FAIL lock_next_pkt got m1v=%b m1d=%h required 1 20", m1_valid, m1_data);
      end
      idle(2);
   endtask

   task automatic test_backpressure;
      int c0;
      m0_ready = 1'b0;
      send_beat(1'b0, 8'h77, 1'b1);
      m1_ready = 1'b0;
      send_beat(1'b1, 8'h55, 1'b0);
      sel    = 1'b0;
      s_data = 8'h56;
      s_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (s_ready !== 1'b0 || m1_valid !== 1'b1 || m1_data !== 8'h55) begin
            errors++;
            $display("FAIL bp_hold got s_ready=%b m1v=%b m1d=%h required 0 1 55",
                     s_ready, m1_valid, m1_data);
         end
      end
      @(posedge clk);
      #1;
      m0_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (m0_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_out0_drain got m0v=%b required 0", m0_valid);
      end
      m1_ready = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got s_ready=%b required 1", s_ready);
      end
      c0 = cyc;
      send_beat(1'b0, 8'h56, 1'b0);
      send_beat(1'b0, 8'h57, 1'b0);
      send_beat(1'b0, 8'h58, 1'b1);
      checks++;
      if (cyc - c0 !== 3) begin
         errors++;
         $display("FAIL bp_throughput got %0d cycles required 3", cyc - c0);
      end
      idle(3);
   endtask

   task automatic test_reset_mid_packet;
      m1_ready = 1'b1;
      send_beat(1'b1, 8'hA0, 1'b0);
      send_beat(1'b0, 8'hA1, 1'b0);
      m1_ready = 1'b0;
      s_valid  = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q0.delete();
      q1.delete();
      model_state = 0;
      m1_ready = 1'b1;
      checks++;
      if (m1_valid !== 1'b0 || dut.state_q !== 2'd0) begin
         errors++;
         $display("FAIL rst_mid got m1v=%b state=%0d required 0 0", m1_valid, dut.state_q);
      end
      send_beat(1'b0, 8'hB0, 1'b1);
      checks++;
      if (m0_valid !== 1'b1 || m0_data !== 8'hB0 || m1_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_reroute got m0v=%b m0d=%h m1v=%b required 1 b0 0",
                  m0_valid, m0_data, m1_valid);
      end
      idle(2);
   endtask

`ifdef DEMUX_CNT_EN
   task automatic test_counters;
      test_reset();
      m0_ready = 1'b1;
      m1_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         send_beat(1'b0, 8'(8'hC0 + i), 1'b1);
      end
      idle(3);
      checks++;
      if (cnt0 !== 4'd1 || cnt1 !== 4'd0) begin
         errors++;
         $display("FAIL cnt_wrap got cnt0=%0d cnt1=%0d required 1 0", cnt0, cnt1);
      end
   endtask
`endif

   task automatic test_drained;
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty got %0d %0d pending required 0 0", q0.size(), q1.size());
      end
   endtask

   initial begin
      rst      = 1'b1;
      sel      = 1'b0;
      s_data   = '0;
      s_last   = 1'b0;
      s_valid  = 1'b0;
      m0_ready = 1'b1;
      m1_ready = 1'b1;
      test_reset();
      test_single_beat();
      test_packet_lock();
      test_backpressure();
      test_reset_mid_packet();
`ifdef DEMUX_CNT_EN
      test_counters();
`endif
      test_drained();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
